// File: rtl/rr_packet_mux_arbiter.sv
// rr_packet_mux_arbiter: packet-locked round-robin arbiter feeding a shared mux and output register
module rr_packet_mux_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       i_in_valid,
    input  logic [N-1:0]       i_in_last,
    input  logic [N*WIDTH-1:0] i_in_data,
    output logic [N-1:0]       o_in_ready,
    output logic               o_out_valid,
    output logic [WIDTH-1:0]   o_out_data,
    output logic [IDW-1:0]     o_out_id,
    output logic               o_out_last,
    input  logic               i_out_ready
);
    logic             r_locked;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   r_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [IDW-1:0]   r_out_id;
    logic             r_out_last;
    logic             w_can_load;
    logic             w_found;
    logic [IDW-1:0]   w_winner;
    logic             w_accept;

    assign w_can_load  = !r_out_valid || i_out_ready;
    assign w_accept    = w_can_load && w_found;
    assign o_in_ready  = w_accept ? (N'(1) << w_winner) : '0;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_id    = r_out_id;
    assign o_out_last  = r_out_last;

    // Pick the winner: the lock owner while mid-packet, otherwise the first valid requester after ptr
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        if (r_locked) begin
            w_found  = i_in_valid[r_owner];
            w_winner = r_owner;
        end else begin
            // scan backwards so the last hit written is the nearest one after ptr
            for (int k = N; k >= 1; k--) begin
                if (i_in_valid[(int'(r_ptr) + k) % N]) begin
                    w_found  = 1'b1;
                    w_winner = IDW'((int'(r_ptr) + k) % N);
                end
            end
        end
    end

    // Load the output register on accept, track packet lock and advance ptr on final beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked    <= 1'b0;
            r_owner     <= '0;
            r_ptr       <= IDW'(N - 1);
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= i_in_data[w_winner*WIDTH +: WIDTH];
            r_out_id    <= w_winner;
            r_out_last  <= i_in_last[w_winner];
            if (i_in_last[w_winner]) begin
                r_locked <= 1'b0;
                r_ptr    <= w_winner;
            end else begin
                r_locked <= 1'b1;
                r_owner  <= w_winner;
            end
        end else if (i_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rr_packet_mux_arbiter.sv
// tb_rr_packet_mux_arbiter: directed scoreboard bench for the packet round-robin arbiter
module tb_rr_packet_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [15:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [1:0]  out_id;
    logic        out_last;
    logic        out_ready;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       last;
    } beat_t;

    beat_t q[$];
    int    errors = 0;
    int    checks = 0;

    rr_packet_mux_arbiter #(.N(4), .WIDTH(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_in_valid(in_valid),
        .i_in_last(in_last),
        .i_in_data(in_data),
        .o_in_ready(in_ready),
        .o_out_valid(out_valid),
        .o_out_data(out_data),
        .o_out_id(out_id),
        .o_out_last(out_last),
        .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, check the grant, then score the beat the DUT registers
    task automatic step(input logic [3:0] v, input logic [3:0] l, input logic [15:0] d,
                        input logic ordy, input logic [3:0] exp_rdy);
        beat_t b;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (exp_rdy[i]) b.id = 2'(i);
            b.data = d[b.id*4 +: 4];
            b.last = l[b.id];
            q.push_back(b);
        end
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            b = q.pop_front();
            chk("out_valid", 32'(out_valid), 32'd1);
            chk("out_id", 32'(out_id), 32'(b.id));
            chk("out_data", 32'(out_data), 32'(b.data));
            chk("out_last", 32'(out_last), 32'(b.last));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        in_last   = 4'b0000;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // all requesters single-beat: rotation 0,1,2,3,0
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0001);
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0010);
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0100);
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b1000);
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0001);
        // move ptr to 1 so requester 2 is next in line
        step(4'b0010, 4'b0010, 16'h0060, 1'b1, 4'b0010);
        // requester 2 three-beat packet while requester 1 waits
        step(4'b0110, 4'b0010, 16'h0A90, 1'b1, 4'b0100);
        step(4'b0110, 4'b0010, 16'h0B90, 1'b1, 4'b0100);
        step(4'b0110, 4'b0110, 16'h0C90, 1'b1, 4'b0100);
        step(4'b0010, 4'b0010, 16'h0090, 1'b1, 4'b0010);
        // backpressure holds the registered beat and blocks all grants
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b1111, 16'h4321, 1'b0, 4'b0000);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_out_id", 32'(out_id), 32'd1);
            chk("bp_out_data", 32'(out_data), 32'h9);
            chk("bp_out_last", 32'(out_last), 32'd1);
        end
        step(4'b1111, 4'b1111, 16'h4321, 1'b1, 4'b0100);
        // owner 3 stalls mid-packet; requester 0 must not be served
        step(4'b1001, 4'b0001, 16'h7005, 1'b1, 4'b1000);
        step(4'b0001, 4'b0001, 16'h7005, 1'b1, 4'b0000);
        chk("stall_out_valid1", 32'(out_valid), 32'd0);
        step(4'b0001, 4'b0001, 16'h7005, 1'b1, 4'b0000);
        chk("stall_out_valid2", 32'(out_valid), 32'd0);
        step(4'b1001, 4'b1001, 16'h8005, 1'b1, 4'b1000);
        // lock on requester 1, then reset mid-packet
        step(4'b0010, 4'b0000, 16'h00D0, 1'b1, 4'b0010);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'd0);
        chk("mid_rst_out_id", 32'(out_id), 32'd0);
        chk("mid_rst_out_last", 32'(out_last), 32'd0);
        #1;
        rst_n = 1'b1;
        step(4'b0011, 4'b0011, 16'h00E1, 1'b1, 4'b0001);
        // lone requester 3 granted every cycle, then 0 wins after ptr wraps
        step(4'b1000, 4'b1000, 16'h5000, 1'b1, 4'b1000);
        step(4'b1000, 4'b1000, 16'h6000, 1'b1, 4'b1000);
        step(4'b1000, 4'b1000, 16'h7000, 1'b1, 4'b1000);
        step(4'b1001, 4'b1001, 16'h7002, 1'b1, 4'b0001);
        step(4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rr_packet_mux_arbiter.md
Name: rr_packet_mux_arbiter

Overview:
- Round-robin arbiter that shares one N:1 data mux and one output register between N requesters.
- Each requester offers WIDTH-bit beats with valid/ready; multi-beat packets are delimited by in_last.
- Once a requester wins, the grant is locked to it until its last beat is accepted, so packets never interleave.
- Sits in front of any single-consumer datapath, such as a shared bus or shared compute unit, that would otherwise be driven by a bare selector mux.

Parameters:
- N, 4, number of requesters (N >= 2).
- WIDTH, 4, data bits per beat.
- IDW, $clog2(N), width of the requester id.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  N  bit i: requester i has a beat.
- in_last  input  N  bit i: requester i's current beat ends its packet.
- in_data  input  N*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH].
- in_ready  output  N  bit i: beat from requester i is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered beat data.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_last  output  1  registered copy of the accepted beat's in_last.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset: asserting rst_n low immediately forces the following values, with no clock needed.
  - out_valid=0, out_data=0, out_id=0, out_last=0.
  - locked=0, owner=0, ptr=N-1, so requester 0 has first priority.
  - This applies even mid-packet; any partial packet is dropped and the lock is released.
- can_load = !out_valid || out_ready. The output register is single-entry, and the block sustains one beat per cycle when out_ready is held high.
- Winner selection (combinational):
  - Locked: winner=owner, and the winner is eligible only if in_valid[owner]=1. All other requesters are ignored.
  - Unlocked: winner is the first i with in_valid[i]=1, scanning ptr+1, ptr+2, ... with modulo-N wrap.
  - No valid requester: no winner.
- in_ready[winner] = can_load && eligible winner. All other in_ready bits are 0.
  - in_ready may depend combinationally on in_valid and out_ready.
  - Requesters must not make in_valid depend on in_ready.
- Accept (in_valid[w] && in_ready[w]), on the next edge:
  - out_data <= in_data[w], out_id <= w, out_last <= in_last[w], out_valid <= 1.
  - If in_last[w]=0: locked <= 1, owner <= w.
  - If in_last[w]=1: locked <= 0, ptr <= w. A single-beat packet never locks.
- No accept while out_valid && out_ready: out_valid <= 0; out_data, out_id and out_last hold their previous values.
- No accept and not draining: all outputs hold. The beat stays stable while out_valid=1 && out_ready=0.
- Locked owner deasserts in_valid mid-packet: the lock holds indefinitely and no other requester is served. A bubble appears on the output.
- Round-robin pointer advances only on a packet's final beat. Fairness is per packet, not per beat.
- Simultaneous drain and accept in one cycle: out_valid stays 1 and the register reloads with the new beat (full throughput).
- Output latency: one cycle from accept to out_valid.
- No combinational path from in_* to out_*. The only combinational paths are in_valid/out_ready/out_valid -> in_ready.

Test Plan:
- Reset, then in_valid=4'b1111, all in_last=1, out_ready=1 held:
  - in_ready grants go 0,1,2,3,0 on consecutive cycles.
  - out_id follows one cycle later, with out_valid continuously 1.
- Requester 2 sends a 3-beat packet (data 0xA,0xB,0xC, last on 0xC) while requester 1 holds valid=1, out_ready=1:
  - Output is 0xA,0xB,0xC with out_id=2 on all three beats.
  - Requester 1's single beat follows next with out_id=1; in_ready[1] stays 0 throughout the packet.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1:
  - out_data, out_id and out_last are stable.
  - All in_ready bits are 0.
  - Raising out_ready accepts the next beat in the same cycle.
- Owner 3 mid-packet drops in_valid for 2 cycles while requester 0 is valid:
  - No grant to requester 0.
  - out_valid falls to 0 after the drain.
  - The packet resumes with out_id=3 when requester 3 is valid again.
- rst_n pulsed low mid-packet (owner=1, locked):
  - All outputs read 0 immediately, without waiting for a clock edge.
  - After release, with in_valid=4'b0011, the first grant goes to requester 0.
- Only requester 3 valid repeatedly with in_last=1:
  - It is granted every cycle.
  - ptr wraps 3->3, and the next grant goes to requester 0 once both 0 and 3 are valid.
